// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing presets, default sync polarities and a small window-decode helper.
package vga_timing_gen_pkg;

  // 640x480@60 (25.175 MHz nominal, 25 MHz from a 50 MHz board clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600@60 (40 MHz pixel)
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  localparam logic DEF_HS_POL = 1'b0;
  localparam logic DEF_VS_POL = 1'b0;

  // True when v lies in the half-open window [lo, lo+len)
  function automatic logic in_span(input int v, input int lo, input int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_clk_enable_div.sv
// Free-running prescaler: ce is high for one clk in every DIV (tied high when DIV=1).
module clk_enable_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic ce
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (reset)               div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                     div_cnt <= div_cnt + CW'(1);
  end

  assign ce = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable prescaler, h/v counters and registered sync/de/coordinate decode.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FP     = VGA640_H_FP,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BP     = VGA640_H_BP,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FP     = VGA640_V_FP,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BP     = VGA640_V_BP,
  parameter logic HS_POL   = DEF_HS_POL,
  parameter logic VS_POL   = DEF_VS_POL,
  parameter int   CLK_DIV  = 2,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 10
) (
  input  logic           clk,
  input  logic           reset,
  output logic           pix_ce,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           line_start,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] H_VIS  = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_VIS  = Y_W'(V_ACTIVE);

  if (CLK_DIV < 1 || CLK_DIV > 16 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing/width parameters");
  end

  clk_enable_div #(.DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .ce    (pix_ce)
  );

  logic [X_W-1:0] h_cnt;
  logic [Y_W-1:0] v_cnt;
  logic           h_wrap, v_wrap, hs_act, vs_act;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign hs_act = in_span(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
  assign vs_act = in_span(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);

  // Outputs capture the pre-increment counters, so x/y/de/syncs stay mutually aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        h_cnt <= h_wrap ? '0 : h_cnt + X_W'(1);
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + Y_W'(1);
        x           <= h_cnt;
        y           <= v_cnt;
        de          <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync       <= hs_act ? HS_POL : ~HS_POL;
        vsync       <= vs_act ? VS_POL : ~VS_POL;
        line_start  <= (h_cnt == '0);
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Three generator configurations on one clock/reset, checked clk-by-clk against an elapsed-time model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // A: defaults. B: tiny, DIV=1, positive syncs. C: small, DIV=3.
  logic a_ce, a_hs, a_vs, a_de, a_ls, a_fs; logic [9:0] a_x, a_y;
  logic b_ce, b_hs, b_vs, b_de, b_ls, b_fs; logic [9:0] b_x, b_y;
  logic c_ce, c_hs, c_vs, c_de, c_ls, c_fs; logic [9:0] c_x, c_y;

  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .pix_ce(a_ce), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs));

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)) u_b (
    .clk(clk), .reset(reset), .pix_ce(b_ce), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .CLK_DIV(3)) u_c (
    .clk(clk), .reset(reset), .pix_ce(c_ce), .hsync(c_hs), .vsync(c_vs), .de(c_de),
    .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs));

  // Expected outputs e clks after the last reset edge, from closed-form pixel arithmetic.
  function automatic logic [37:0] model(input longint e,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input bit hp, input bit vp, input int d);
    int ht, vt, px, py;
    longint p;
    bit ce, h, v, de, ls, fs;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    ce = ((e % d) == d - 1);
    if (e < d) begin
      px = 0; py = 0; de = 0; ls = 0; fs = 0; h = ~hp; v = ~vp;
    end else begin
      p  = e / d - 1;
      px = int'(p % ht);
      py = int'((p / ht) % vt);
      de = (px < ha) && (py < va);
      h  = (px >= ha + hf && px < ha + hf + hs) ? hp : ~hp;
      v  = (py >= va + vf && py < va + vf + vs) ? vp : ~vp;
      ls = ((e % d) == 0) && (px == 0);
      fs = ls && (py == 0);
    end
    return {ce, h, v, de, ls, fs, 16'(px), 16'(py)};
  endfunction

  logic [37:0] qa[$], qb[$], qc[$];
  longint e = 0;
  bit started = 0;

  always @(posedge clk) begin
    if (reset) begin started = 1; e = 0; end
    else e++;
    if (started) begin
      qa.push_back(model(e, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2));
      qb.push_back(model(e, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, 1));
      qc.push_back(model(e, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 3));
    end
  end

  always @(negedge clk) begin
    if (qa.size() > 0) chk("A_outs", 64'({a_ce, a_hs, a_vs, a_de, a_ls, a_fs, 16'(a_x), 16'(a_y)}), 64'(qa.pop_front()));
    if (qb.size() > 0) chk("B_outs", 64'({b_ce, b_hs, b_vs, b_de, b_ls, b_fs, 16'(b_x), 16'(b_y)}), 64'(qb.pop_front()));
    if (qc.size() > 0) chk("C_outs", 64'({c_ce, c_hs, c_vs, c_de, c_ls, c_fs, 16'(c_x), 16'(c_y)}), 64'(qc.pop_front()));
  end

  initial begin
    int t, cyc, de_c, hs_c, xmin, xmax;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // One full default line measured between consecutive line_start pulses
    t = 0;
    while (!a_ls && t < 5000) begin @(negedge clk); t++; end
    chk("A_first_ls_seen", 64'(t < 5000), 64'(1));
    chk("A_first_fs", 64'({a_fs, a_de, 6'(0), a_x, a_y}), 64'({1'b1, 1'b1, 6'(0), 10'd0, 10'd0}));
    cyc = 0; de_c = 0; hs_c = 0; xmin = 1023; xmax = 0;
    do begin
      if (a_de) de_c++;
      if (!a_hs) begin
        hs_c++;
        if (int'(a_x) < xmin) xmin = int'(a_x);
        if (int'(a_x) > xmax) xmax = int'(a_x);
      end
      @(negedge clk);
      cyc++;
    end while (!a_ls && cyc < 2000);
    chk("A_line_period", 64'(cyc), 64'(1600));
    chk("A_de_clks", 64'(de_c), 64'(1280));
    chk("A_hsync_clks", 64'(hs_c), 64'(192));
    chk("A_hsync_xmin", 64'(xmin), 64'(656));
    chk("A_hsync_xmax", 64'(xmax), 64'(751));

    // Tiny config: frame period between frame_start pulses
    t = 0;
    while (!b_fs && t < 200) begin @(negedge clk); t++; end
    chk("B_fs_seen", 64'(t < 200), 64'(1));
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!b_fs && cyc < 200);
    chk("B_frame_period", 64'(cyc), 64'(48));

    // Reset mid-hsync on the default config at (700,1)
    t = 0;
    while (!(a_x == 10'd700 && a_y == 10'd1) && t < 5000) begin @(negedge clk); t++; end
    chk("A_reached_700_1", 64'(t < 5000), 64'(1));
    chk("A_in_hsync", 64'(a_hs), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("A_reset_outs", 64'({a_hs, a_vs, a_de, a_ls, a_fs, a_x, a_y}), 64'({1'b1, 1'b1, 3'b000, 10'd0, 10'd0}));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2000) @(negedge clk);

    // Reset mid-hsync on the DIV=3 config, then let it run a couple of frames
    t = 0;
    while (!(!c_hs && c_y == 10'd2) && t < 2000) begin @(negedge clk); t++; end
    chk("C_reached_hsync", 64'(t < 2000), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
